// File: rtl/sha256_round_pipeline_stage.sv
// One unrolled SHA-256 compression round: registers round(state_in, w_in, K_CONST) and valid_in.
// Latency one write_en-qualified edge; write_en=0 stalls (holds outputs), RST overrides write_en.
module sha256_round_pipeline_stage #(
  parameter int unsigned ROUND_IDX = 31,
  parameter logic [31:0] K_CONST   = 32'h14292967
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         write_en,
  input  logic         valid_in,
  input  logic [255:0] state_in,
  input  logic [31:0]  w_in,
  output logic         valid_out,
  output logic [255:0] state_out
);

  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [5:0] IDX = 6'(ROUND_IDX);

  logic [31:0]  w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
  logic [31:0]  w_s1, w_ch, w_s0, w_maj, w_t1, w_t2;
  logic [255:0] r_state;
  logic         r_valid;

  assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = state_in;

  // Rotations are fixed bit re-orderings, so they cost no logic.
  assign w_s1  = {w_e[5:0], w_e[31:6]} ^ {w_e[10:0], w_e[31:11]} ^ {w_e[24:0], w_e[31:25]};
  assign w_ch  = (w_e & w_f) ^ (~w_e & w_g);
  assign w_s0  = {w_a[1:0], w_a[31:2]} ^ {w_a[12:0], w_a[31:13]} ^ {w_a[21:0], w_a[31:22]};
  assign w_maj = (w_a & w_b) ^ (w_a & w_c) ^ (w_b & w_c);
  assign w_t1  = (w_h + K_CONST) + (w_s1 + w_ch) + w_in;
  assign w_t2  = w_s0 + w_maj;

  // Bubbles still advance the datapath; only valid_out qualifies the data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= '0;
      r_valid <= 1'b0;
    end else if (write_en) begin
      r_state <= {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};
      r_valid <= valid_in;
    end
  end

  assign state_out = r_state;
  assign valid_out = r_valid;

  a_k_const_matches_round: assert property (@(posedge CLK) (ROUND_IDX < 64) && (K_CONST == K_TAB[IDX]));

endmodule
